i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- I2S transmitter; the consuming end of the 24-bit audio AXI-stream produced by the fm synthesizer (Axis_If, DWIDTH 24).
- Accepts mono samples via ready/valid, duplicates each to left and right slots, and serializes to an external DAC.
- Produces bclk/lrclk as I2S master from the 100 MHz system clock.
- Applies back-pressure so the synthesizer runs at exactly one sample per I2S frame.

Parameters:
- BCLK_HALF, 16, system clk cycles per bclk half-period; must be >= 2. Default gives 3.125 MHz bclk and fs of about 48.8 kHz.
- DWIDTH, 24, sample width; must be <= SLOT_BITS-1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high reset.
- sample_in  Axis_If slave  DWIDTH  audio sample stream (data, valid, ready).
- i2s_bclk  output  1  bit clock.
- i2s_lrclk  output  1  word select; 0 = left, 1 = right.
- i2s_sdata  output  1  serial data, MSB first.
- underflow  output  1  one-cycle pulse when a frame starts with no sample available.
- underflow_count  output  16  saturating count of underflow frames.

Behaviour:
- Reset values (all registers, asynchronous): bclk=0, lrclk=1, sdata=0, underflow=0, underflow_count=0, div_cnt=0, bit_cnt=63, holding register empty, active sample=0. sample_in.ready=0 while reset is high.
- Divider: div_cnt counts 0..BCLK_HALF-1. At terminal count bclk toggles and div_cnt wraps. A "fall" strobe is the clk cycle in which bclk goes 1->0.
- Frame timing: bit_cnt (0..63) increments on each fall strobe and wraps 63->0.
  - lrclk, sdata and bit_cnt change only on fall strobes.
  - lrclk=0 for bit_cnt 0..31 and 1 for bit_cnt 32..63.
- Slot format (I2S one-bit delay): slot position p = bit_cnt mod 32.
  - p=1..24: sdata = active[24-p].
  - p=0 and p=25..31: sdata = 0.
  - Left and right slots carry the same active sample.
- Frame tick: the fall strobe on which bit_cnt wraps 63->0. The first fall strobe after reset is a frame tick.
- Holding register (one entry): sample_in.ready = !holding_valid, registered, not combinational on valid.
  - A handshake (valid && ready) loads holding on that clk edge.
- At a frame tick:
  - If holding_valid: active <= holding, holding_valid <= 0; ready returns high the next cycle.
  - Else: active <= 0 (mute frame), underflow pulses for one cycle, underflow_count increments and saturates at 16'hFFFF.
- Simultaneous frame tick and handshake with holding empty: the frame is an underflow. The incoming word goes into holding and is played in the next frame; no sample is dropped.
- Latency: a sample in holding at a frame tick appears MSB-first starting at the next fall strobe (bit_cnt=1), one bclk period after the tick.
- Steady state: exactly one handshake per frame, frame period = 128*BCLK_HALF clk cycles. Sample order is preserved.
- Mid-frame reset: all state returns to reset values immediately, the holding sample is discarded, and the next frame starts fresh.

Decomposition:
- i2s_pkg holds:
  - localparam SLOT_BITS=32, FRAME_BITS=64.
  - typedef logic [23:0] sample_t.
  - function computing bit position within a slot.
- Sub-module i2s_clk_gen: div_cnt/bclk register, outputs bclk and fall strobe, parameter BCLK_HALF. The top level holds the handshake, holding/active registers, bit_cnt, lrclk, sdata and the underflow logic.

Test Plan:
- Reset (BCLK_HALF=4): during reset bclk=0, lrclk=1, sdata=0, ready=0; ready=1 on the first edge after release. First fall strobe at cycle 8 after release, with lrclk going to 0.
- Single sample 24'hA5F00F sent before the first tick -> bench I2S decoder reads A5F00F in both left and right slots. Slot bit 0 and bits 25..31 are 0. First bit (1) appears at bit_cnt=1.
- No samples for 4 frames -> sdata constant 0, underflow pulses 4 times spaced 512 clks apart (BCLK_HALF=4), underflow_count=4.
- Continuous valid with incrementing data 1,2,3,... -> ready low except one cycle per frame, one accept per 512 clks, decoder output sequence 1,2,3,... with no gaps. Force underflow_count to 16'hFFFE, then trigger 3 underflows -> count stops at 16'hFFFF.
- Handshake timed on the same cycle as a frame tick with holding empty -> underflow pulse that frame; the sample is decoded in the following frame.
- Assert reset at bit_cnt=40 with a sample in holding -> outputs immediately at reset values, count=0. After release, the first frame underflows unless a new sample is sent; the discarded sample never appears.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants, types and helpers for the I2S transmitter.
package i2s_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef logic [23:0] sample_t;

  // Position of a frame bit inside its 32-bit slot (0 = the I2S delay bit).
  function automatic logic [4:0] slot_pos(input logic [5:0] bit_cnt);
    return bit_cnt[4:0];
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream bundle: data plus ready/valid handshake.
interface Axis_If #(
  parameter int DWIDTH = 24
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF system clocks and flags
// the cycle whose edge takes bclk from 1 to 0.
module i2s_clk_gen #(
  parameter int BCLK_HALF = 16
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic fall
);

  localparam int CW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [CW-1:0] div_cnt;
  logic          tc;

  assign tc   = (div_cnt == CW'(BCLK_HALF - 1));
  assign fall = tc & bclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one mono sample per frame, duplicated to both
// slots, with a one-entry holding register pacing the upstream stream.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = 16,
  parameter int DWIDTH    = 24
) (
  input  logic        clk,
  input  logic        reset,
  Axis_If.slave       sample_in,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underflow,
  output logic [15:0] underflow_count
);

  logic              fall;
  logic              tick;
  logic              hs;
  logic              uf_set;
  logic [5:0]        bit_cnt;
  logic [5:0]        bit_nxt;
  logic [4:0]        pos;
  logic              sdata_n;
  logic [DWIDTH-1:0] holding;
  logic [DWIDTH-1:0] active;
  logic              hold_vld;
  logic              hold_nxt;
  logic              ready_q;
  logic [15:0]       ucnt_q;

  i2s_clk_gen #(.BCLK_HALF(BCLK_HALF)) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .bclk  (i2s_bclk),
    .fall  (fall)
  );

  assign tick     = fall && (bit_cnt == 6'(FRAME_BITS - 1));
  assign hs       = sample_in.valid && ready_q;
  assign uf_set   = tick && !hold_vld;
  assign bit_nxt  = bit_cnt + 6'd1;
  assign pos      = slot_pos(bit_nxt);

  // Ready is only ever offered when nothing is held, so a handshake can
  // never coincide with a tick that drains a full holding register.
  assign hold_nxt = (hold_vld && !tick) || hs;

  assign sample_in.ready = ready_q;
  assign underflow_count = ucnt_q;

  // One-bit I2S delay: slot position p carries active[DWIDTH-p], MSB first.
  always_comb begin
    sdata_n = 1'b0;
    for (int i = 0; i < DWIDTH; i++) begin
      if (int'(pos) == DWIDTH - i) sdata_n = active[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holding  <= '0;
      hold_vld <= 1'b0;
      ready_q  <= 1'b0;
      active   <= '0;
    end else begin
      if (hs) holding <= sample_in.data;
      if (tick) active <= hold_vld ? holding : '0;
      hold_vld <= hold_nxt;
      ready_q  <= !hold_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= 6'(FRAME_BITS - 1);
      i2s_lrclk <= 1'b1;
      i2s_sdata <= 1'b0;
    end else if (fall) begin
      bit_cnt   <= bit_nxt;
      i2s_lrclk <= (int'(bit_nxt) >= SLOT_BITS);
      i2s_sdata <= sdata_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      underflow <= uf_set;
      if (uf_set && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at BCLK_HALF=4 (512-clock frames) with an
// independent I2S decoder that samples sdata on rising bclk.
module tb_i2s_tx;

  logic        clk;
  logic        reset;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, underflow;
  logic [15:0] underflow_count;

  Axis_If #(.DWIDTH(24)) axis ();

  i2s_tx #(.BCLK_HALF(4), .DWIDTH(24)) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_in       (axis),
    .i2s_bclk        (i2s_bclk),
    .i2s_lrclk       (i2s_lrclk),
    .i2s_sdata       (i2s_sdata),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Underflow pulse log (cycle numbers of each pulse).
  int uf_n    = 0;
  int last_uf = 0;
  int uf_t[$];
  always @(negedge clk) begin
    if (underflow === 1'b1) begin
      uf_n++;
      last_uf = cyc;
      uf_t.push_back(cyc);
    end
  end

  // I2S decoder: an lrclk change marks slot position 0.
  int          pos     = -1;
  logic        prev_lr = 1'b1;
  logic [23:0] sh      = '0;
  int          pad_err = 0;
  logic [23:0] left_q[$];
  logic [23:0] right_q[$];
  always @(posedge i2s_bclk or posedge reset) begin
    if (reset) begin
      pos     = -1;
      prev_lr = 1'b1;
    end else begin
      if (i2s_lrclk !== prev_lr) pos = 0;
      else if (pos >= 0) pos++;
      prev_lr = i2s_lrclk;
      if (pos >= 1 && pos <= 24) sh = {sh[22:0], i2s_sdata};
      else if (pos == 0 || (pos >= 25 && pos <= 31)) begin
        if (i2s_sdata !== 1'b0) pad_err++;
      end
      if (pos == 24) begin
        if (i2s_lrclk) right_q.push_back(sh);
        else left_q.push_back(sh);
      end
    end
  end

  function automatic logic [23:0] lq(input int i);
    if (i < left_q.size()) return left_q[i];
    return 'x;
  endfunction

  function automatic logic [23:0] rq(input int i);
    if (i < right_q.size()) return right_q[i];
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int base, qb, rb, n0, c0, acc, rdy_hi;
  int acc_cyc[6];
  logic hs;

  initial begin
    reset = 1'b1;
    axis.valid = 1'b0;
    axis.data  = '0;
    repeat (3) step();

    // Reset state
    chk("rst_bclk",  i2s_bclk, 0);
    chk("rst_lrclk", i2s_lrclk, 1);
    chk("rst_sdata", i2s_sdata, 0);
    chk("rst_ready", axis.ready, 0);
    chk("rst_uf",    underflow, 0);
    chk("rst_cnt",   underflow_count, 0);

    reset = 1'b0;
    step();                                   // edge 1
    chk("rdy_after_rel", axis.ready, 1);
    axis.valid = 1'b1;
    axis.data  = 24'hA5F00F;
    step();                                   // edge 2: handshake
    chk("rdy_after_hs", axis.ready, 0);
    axis.valid = 1'b0;
    repeat (2) step();                        // edge 4
    chk("bclk_rise4", i2s_bclk, 1);
    repeat (3) step();                        // edge 7
    chk("lr_pre_fall", i2s_lrclk, 1);
    step();                                   // edge 8: first fall, frame tick
    chk("lr_fall8",   i2s_lrclk, 0);
    chk("bclk_fall8", i2s_bclk, 0);
    chk("sd_bit0",    i2s_sdata, 0);
    chk("rdy_tick",   axis.ready, 1);
    chk("uf_tick1",   underflow, 0);
    repeat (8) step();                        // edge 16: bit_cnt=1
    chk("sd_bit1", i2s_sdata, 1);
    repeat (8) step();                        // edge 24: bit_cnt=2
    chk("sd_bit2", i2s_sdata, 0);

    // Single sample decoded in both slots
    for (int n = 0; n < 1500 && !(left_q.size() >= 1 && right_q.size() >= 1); n++) step();
    chk("to_dec1", (left_q.size() >= 1 && right_q.size() >= 1), 1);
    chk("dec_l0", lq(0), 24'hA5F00F);
    chk("dec_r0", rq(0), 24'hA5F00F);

    // Four underflow frames
    for (int n = 0; n < 2600 && uf_n < 4; n++) step();
    chk("uf_n4",   uf_n, 4);
    chk("uf_cnt4", underflow_count, 4);
    for (int i = 1; i < 4; i++) chk("uf_space", uf_t[i] - uf_t[i-1], 512);
    for (int i = 1; i < 4; i++) begin
      chk("mute_l", lq(i), 0);
      chk("mute_r", rq(i), 0);
    end
    chk("pad_zero", pad_err, 0);

    // Continuous stream 1..6
    base = left_q.size() + 1;
    axis.valid = 1'b1;
    axis.data  = 24'd1;
    acc = 0; rdy_hi = 0; hs = 1'b0;
    for (int n = 0; n < 4000 && acc < 6; n++) begin
      if (axis.ready === 1'b1) begin
        rdy_hi++;
        acc_cyc[acc] = cyc;
        acc++;
        hs = 1'b1;
      end
      step();
      if (hs) begin
        hs = 1'b0;
        if (acc < 6) axis.data = axis.data + 24'd1;
      end
    end
    axis.valid = 1'b0;
    chk("acc6",   acc, 6);
    chk("rdy_hi", rdy_hi, 6);
    for (int i = 2; i < 6; i++) chk("acc_space", acc_cyc[i] - acc_cyc[i-1], 512);
    for (int n = 0; n < 1500 && !(left_q.size() >= base + 6 && right_q.size() >= base + 6); n++) step();
    chk("to_stream", (left_q.size() >= base + 6 && right_q.size() >= base + 6), 1);
    chk("stream_mute", lq(base - 1), 0);
    for (int i = 0; i < 6; i++) begin
      chk("stream_l", lq(base + i), 24'(i + 1));
      chk("stream_r", rq(base + i), 24'(i + 1));
    end

    // Saturation
    n0 = uf_n;
    for (int n = 0; n < 1200 && uf_n <= n0; n++) step();
    chk("to_uf5",  uf_n > n0, 1);
    chk("uf_cnt5", underflow_count, 5);
    force dut.ucnt_q = 16'hFFFE;
    step();
    release dut.ucnt_q;
    step();
    chk("cnt_fffe", underflow_count, 16'hFFFE);
    for (int n = 0; n < 700 && uf_n < n0 + 2; n++) step();
    chk("cnt_sat1", underflow_count, 16'hFFFF);
    for (int n = 0; n < 1200 && uf_n < n0 + 4; n++) step();
    chk("uf_sat_n", uf_n, n0 + 4);
    chk("cnt_sat3", underflow_count, 16'hFFFF);

    // Handshake on the same edge as a frame tick
    c0 = last_uf;
    for (int n = 0; n < 600 && cyc != c0 + 511; n++) step();
    chk("to_align", cyc, c0 + 511);
    chk("rdy_pre_tick", axis.ready, 1);
    qb = left_q.size();
    rb = right_q.size();
    axis.valid = 1'b1;
    axis.data  = 24'h3C5A96;
    step();
    axis.valid = 1'b0;
    chk("coinc_uf",  underflow, 1);
    chk("coinc_rdy", axis.ready, 0);
    for (int n = 0; n < 1500 && !(left_q.size() >= qb + 2 && right_q.size() >= rb + 2); n++) step();
    chk("coinc_mute", lq(qb), 0);
    chk("coinc_l",    lq(qb + 1), 24'h3C5A96);
    chk("coinc_r",    rq(rb + 1), 24'h3C5A96);

    // Mid-frame reset at bit_cnt=40 with a held sample
    n0 = uf_n;
    for (int n = 0; n < 700 && uf_n <= n0; n++) step();
    c0 = last_uf;
    axis.valid = 1'b1;
    axis.data  = 24'h123456;
    step();
    axis.valid = 1'b0;
    chk("held_rdy", axis.ready, 0);
    for (int n = 0; n < 400 && cyc != c0 + 326; n++) step();
    chk("pre_rst_bclk", i2s_bclk, 1);
    chk("pre_rst_lr",   i2s_lrclk, 1);
    reset = 1'b1;
    #1;
    chk("mrst_bclk",  i2s_bclk, 0);
    chk("mrst_lr",    i2s_lrclk, 1);
    chk("mrst_sdata", i2s_sdata, 0);
    chk("mrst_cnt",   underflow_count, 0);
    chk("mrst_rdy",   axis.ready, 0);
    repeat (3) step();
    reset = 1'b0;
    qb = left_q.size();
    rb = right_q.size();
    n0 = uf_n;
    for (int n = 0; n < 20 && uf_n <= n0; n++) step();
    chk("post_uf",  uf_n, n0 + 1);
    chk("post_cnt", underflow_count, 1);
    for (int n = 0; n < 1500 && !(left_q.size() >= qb + 2 && right_q.size() >= rb + 2); n++) step();
    chk("post_l0", lq(qb), 0);
    chk("post_l1", lq(qb + 1), 0);
    chk("post_r0", rq(rb), 0);
    chk("post_r1", rq(rb + 1), 0);
    chk("pad_end", pad_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
